// File: rtl/axi_lite_regfile_pkg.sv
// Shared response codes, channel state types and decode helper for the
// AXI4-Lite register file.
package axi_lite_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_wr_fsm.sv
// Write-channel controller: joins AW and W in either order, issues a single
// wr_en strobe to the register array and owns the B response.
module axi_lite_regfile_wr_fsm
    import axi_lite_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH),
    localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  wr_en,
    output logic [IDX_WIDTH-1:0]  wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [STRB_WIDTH-1:0] wr_strb
);

    wr_state_t             state;
    wr_state_t             state_next;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  complete;
    logic                  in_range;
    logic [IDX_WIDTH-1:0]  idx_eff;
    logic                  unused_addr_bits;

    assign awready = active && ((state == WR_IDLE) || (state == WR_WAIT_AW));
    assign wready  = active && ((state == WR_IDLE) || (state == WR_WAIT_W));
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Whichever half arrived first comes from its latch, the other straight from the bus.
    assign idx_eff  = (state == WR_WAIT_W)  ? idx_q  : awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data  = (state == WR_WAIT_AW) ? data_q : wdata;
    assign wr_strb  = (state == WR_WAIT_AW) ? strb_q : wstrb;
    assign in_range = idx_in_range(32'(idx_eff), NUM_REGS);

    assign wr_en  = complete && in_range;
    assign wr_idx = idx_eff;
    assign bvalid = (state == WR_RESP);
    assign bresp  = bresp_q;

    assign unused_addr_bits = ^awaddr[ADDR_LSB-1:0];

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_next = WR_RESP;
                    complete   = 1'b1;
                end else if (aw_hs) begin
                    state_next = WR_WAIT_W;
                end else if (w_hs) begin
                    state_next = WR_WAIT_AW;
                end
            end
            WR_WAIT_W: begin
                if (w_hs) begin
                    state_next = WR_RESP;
                    complete   = 1'b1;
                end
            end
            WR_WAIT_AW: begin
                if (aw_hs) begin
                    state_next = WR_RESP;
                    complete   = 1'b1;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_next = WR_IDLE;
                end
            end
            default: state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WR_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state <= state_next;
            if (aw_hs) begin
                idx_q <= awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (complete) begin
                bresp_q <= in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite slave register file with byte strobes, read-only
// hardware-fed registers, per-register write pulses and SLVERR decode.
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 6,
    parameter int                            C_NUM_REGS         = 16,
    parameter logic [C_NUM_REGS-1:0]         C_RO_MASK          = '0,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RESET_VAL        = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [C_NUM_REGS-1:0]                  reg_wr_pulse
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int SW        = DW / 8;
    localparam int ADDR_LSB  = $clog2(SW);
    localparam int IDX_WIDTH = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    logic                 active;
    logic                 wr_en;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic [DW-1:0]        wr_data;
    logic [SW-1:0]        wr_strb;

    logic [DW-1:0]         regs [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] wr_pulse_q;

    rd_state_t            rd_state;
    rd_state_t            rd_state_next;
    logic [DW-1:0]        rdata_q;
    logic [DW-1:0]        rd_word;
    logic [1:0]           rresp_q;
    logic                 ar_hs;
    logic [IDX_WIDTH-1:0] ar_idx;
    logic                 ar_in_range;
    logic                 unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};

    // Holds every READY low until the first clock edge after reset releases.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    axi_lite_regfile_wr_fsm #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS   (C_NUM_REGS)
    ) u_wr_fsm (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .active  (active),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

    // Read-only slots are never written and stay zero; their visible value comes from reg_in.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                regs[k] <= C_RO_MASK[k] ? '0 : C_RESET_VAL;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                if (!C_RO_MASK[k] && wr_en && (wr_idx == IDX_WIDTH'(k)) && (|wr_strb)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wr_strb[b]) begin
                            regs[k][b*8 +: 8] <= wr_data[b*8 +: 8];
                        end
                    end
                    wr_pulse_q[k] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
        assign reg_out[k*DW +: DW] = regs[k];
    end

    assign reg_wr_pulse = wr_pulse_q;

    assign S_AXI_ARREADY = active && (rd_state == RD_IDLE);
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_in_range   = idx_in_range(32'(ar_idx), C_NUM_REGS);

    // An out-of-range index matches no slot and falls through to zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (ar_idx == IDX_WIDTH'(k)) begin
                rd_word = C_RO_MASK[k] ? reg_in[k*DW +: DW] : regs[k];
            end
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_next;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign S_AXI_RVALID = (rd_state == RD_RESP);
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomised scoreboard bench for axi_lite_regfile: drivers push expected B/R
// responses from a word-array model, negedge monitors pop and compare.
module tb_axi_lite_regfile;

    localparam int                DW      = 32;
    localparam int                AW      = 6;
    localparam int                NREGS   = 4;
    localparam int                FW      = NREGS * DW;
    localparam logic [NREGS-1:0]  RO_MASK = 4'b0010;
    localparam logic [DW-1:0]     RST_VAL = 32'h0000_00A5;
    localparam logic [1:0]        OKAY    = 2'b00;
    localparam logic [1:0]        SLVERR  = 2'b10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [AW-1:0]    awaddr = '0;
    logic [2:0]       awprot = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [DW-1:0]    wdata = '0;
    logic [DW/8-1:0]  wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b0;
    logic [AW-1:0]    araddr = '0;
    logic [2:0]       arprot = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [FW-1:0]    reg_out;
    logic [FW-1:0]    reg_in = '0;
    logic [NREGS-1:0] reg_wr_pulse;

    typedef struct {
        logic [1:0]       resp;
        logic [NREGS-1:0] pulse;
        logic [FW-1:0]    regs;
    } b_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    b_exp_t        bq[$];
    r_exp_t        rq[$];
    logic [DW-1:0] model_regs [NREGS];
    int            checks = 0;
    int            errors = 0;
    bit            bvalid_prev = 1'b0;

    always #5 clk = ~clk;

    axi_lite_regfile #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_NUM_REGS         (NREGS),
        .C_RO_MASK          (RO_MASK),
        .C_RESET_VAL        (RST_VAL)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    task automatic checkOutput(input string name, input logic [FW-1:0] actual, input logic [FW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [FW-1:0] rw_mask();
        logic [FW-1:0] m;
        m = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (!RO_MASK[k]) m[k*DW +: DW] = '1;
        end
        return m;
    endfunction

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < NREGS; k++) f[k*DW +: DW] = model_regs[k];
        return f;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NREGS; k++) model_regs[k] = RST_VAL;
    endfunction

    function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
        int     idx;
        b_exp_t e;
        idx     = int'(addr) / 4;
        e.pulse = '0;
        if (idx >= NREGS) begin
            e.resp = SLVERR;
        end else begin
            e.resp = OKAY;
            if (!RO_MASK[idx] && strb != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
                end
                e.pulse[idx] = 1'b1;
            end
        end
        e.regs = model_flat();
        bq.push_back(e);
    endfunction

    function automatic void model_read(input logic [AW-1:0] addr);
        int     idx;
        r_exp_t e;
        idx = int'(addr) / 4;
        if (idx >= NREGS) begin
            e.data = '0;
            e.resp = SLVERR;
        end else if (RO_MASK[idx]) begin
            e.data = reg_in[idx*DW +: DW];
            e.resp = OKAY;
        end else begin
            e.data = model_regs[idx];
            e.resp = OKAY;
        end
        rq.push_back(e);
    endfunction

    // Drivers start and finish at posedge+1; b_dly < 0 leaves the response pending.
    task automatic write_drive(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_fire, w_fire, fire;
        int cyc, need, cnt;
        aw_done = 0; w_done = 0; fire = 0; cyc = 0; cnt = 0;
        need    = (aw_dly > w_dly) ? aw_dly : w_dly;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        while (!(aw_done && w_done) && cyc < 64) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk);
            #1;
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            if (!(aw_done && w_done)) cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            reportFail("wr_handshake_timeout");
            return;
        end
        checkOutput("b_latency", FW'(cyc), FW'(need));
        checkOutput("bvalid_rise", FW'(bvalid), FW'(1));
        if (b_dly < 0) return;
        for (int i = 0; i < b_dly; i++) begin
            awaddr  = addr ^ 6'h04;
            awvalid = 1'b1;
            @(negedge clk);
            checkOutput("awready_in_resp", FW'(awready), FW'(0));
            checkOutput("wready_in_resp", FW'(wready), FW'(0));
            checkOutput("bvalid_hold", FW'(bvalid), FW'(1));
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        bready  = 1'b1;
        while (!fire && cnt < 64) begin
            @(negedge clk);
            fire = bvalid;
            @(posedge clk);
            #1;
            cnt++;
        end
        bready = 1'b0;
        if (!fire) reportFail("b_handshake_timeout");
    endtask

    task automatic read_drive(input logic [AW-1:0] addr, input int ar_dly, input int r_dly);
        bit done, fire;
        int cyc, cnt;
        done = 0; fire = 0; cyc = 0; cnt = 0;
        araddr = addr;
        while (!done && cyc < 64) begin
            arvalid = (cyc >= ar_dly);
            @(negedge clk);
            fire = arvalid && arready;
            @(posedge clk);
            #1;
            if (fire) done = 1;
            else cyc++;
        end
        arvalid = 1'b0;
        if (!done) begin
            reportFail("rd_handshake_timeout");
            return;
        end
        checkOutput("ar_latency", FW'(cyc), FW'(ar_dly));
        checkOutput("rvalid_rise", FW'(rvalid), FW'(1));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            checkOutput("rvalid_hold", FW'(rvalid), FW'(1));
            checkOutput("arready_in_resp", FW'(arready), FW'(0));
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        fire   = 0;
        while (!fire && cnt < 64) begin
            @(negedge clk);
            fire = rvalid;
            @(posedge clk);
            #1;
            cnt++;
        end
        rready = 1'b0;
        if (!fire) reportFail("r_handshake_timeout");
    endtask

    // kind 0 = write, 1 = read, 2 = read and write to one address on the same edge.
    task automatic applyStimulus(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] strb, input int d_a, input int d_w, input int d_resp);
        case (kind)
            0: begin
                model_write(addr, data, strb);
                write_drive(addr, data, strb, d_a, d_w, d_resp);
            end
            1: begin
                model_read(addr);
                read_drive(addr, d_a, d_resp);
            end
            default: begin
                model_read(addr);
                model_write(addr, data, strb);
                fork
                    write_drive(addr, data, strb, 0, 0, d_resp);
                    read_drive(addr, 0, d_resp);
                join
            end
        endcase
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        bq.delete();
        rq.delete();
        model_reset();
        checkOutput("rst_bvalid", FW'(bvalid), FW'(0));
        checkOutput("rst_rvalid", FW'(rvalid), FW'(0));
        checkOutput("rst_ready", FW'({awready, wready, arready}), FW'(0));
        checkOutput("rst_pulse", FW'(reg_wr_pulse), FW'(0));
        checkOutput("rst_resp_data", FW'({bresp, rresp, rdata}), FW'(0));
        checkOutput("rst_reg_out", reg_out & rw_mask(), model_flat() & rw_mask());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_before_edge", FW'({awready, wready, arready}), FW'(0));
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", FW'({awready, wready, arready}), FW'(3'b111));
    endtask

    // B monitor checks pulse and reg_out on the first BVALID cycle, BRESP every held cycle.
    always @(negedge clk) begin
        if (rst) begin
            bvalid_prev = 1'b0;
        end else begin
            if (bvalid) begin
                if (bq.size() == 0) begin
                    reportFail("b_unexpected");
                end else begin
                    if (!bvalid_prev) begin
                        checkOutput("wr_pulse", FW'(reg_wr_pulse), FW'(bq[0].pulse));
                        checkOutput("reg_out", reg_out & rw_mask(), bq[0].regs & rw_mask());
                    end else begin
                        checkOutput("wr_pulse_single", FW'(reg_wr_pulse), FW'(0));
                    end
                    checkOutput("bresp", FW'(bresp), FW'(bq[0].resp));
                    if (bready) void'(bq.pop_front());
                end
            end else begin
                checkOutput("wr_pulse_idle", FW'(reg_wr_pulse), FW'(0));
            end
            bvalid_prev = bvalid;
            if (rvalid) begin
                if (rq.size() == 0) begin
                    reportFail("r_unexpected");
                end else begin
                    checkOutput("rdata", FW'(rdata), FW'(rq[0].data));
                    checkOutput("rresp", FW'(rresp), FW'(rq[0].resp));
                    if (rready) void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        reg_in = {32'h1357_9BDF, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h5555_AAAA};
        apply_reset();

        for (int i = 0; i < 4; i++) applyStimulus(0, AW'(i * 4), DW'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, AW'(i * 4), '0, 4'h0, 0, 0, 0);

        applyStimulus(0, 6'h00, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
        applyStimulus(0, 6'h00, 32'h1122_3344, 4'b0101, 1, 0, 0);
        checkOutput("strobe_merge", FW'(reg_out[31:0]), FW'(32'hAA22_CC44));
        applyStimulus(1, 6'h00, '0, 4'h0, 0, 0, 1);

        applyStimulus(0, 6'h08, 32'h0000_0C0C, 4'hF, 3, 0, 0);
        applyStimulus(0, 6'h0C, 32'h0F0F_0F0F, 4'hF, 0, 2, 5);
        applyStimulus(0, 6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 2);
        applyStimulus(0, 6'h3C, 32'h1234_5678, 4'hF, 0, 0, 0);
        applyStimulus(1, 6'h10, '0, 4'h0, 0, 0, 0);
        applyStimulus(1, 6'h2B, '0, 4'h0, 2, 0, 3);
        applyStimulus(0, 6'h04, 32'h0000_0005, 4'hF, 0, 0, 0);
        applyStimulus(1, 6'h04, '0, 4'h0, 0, 0, 0);
        applyStimulus(0, 6'h0C, 32'h9999_9999, 4'h0, 0, 0, 0);
        applyStimulus(2, 6'h08, 32'h7777_0000, 4'hF, 0, 0, 0);
        applyStimulus(1, 6'h08, '0, 4'h0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            a = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) reg_in[DW +: DW] = $urandom;
            applyStimulus($urandom_range(0, 2), a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        applyStimulus(0, 6'h08, 32'hCAFE_F00D, 4'hF, 0, 0, -1);
        apply_reset();
        applyStimulus(1, 6'h08, '0, 4'h0, 0, 0, 0);
        applyStimulus(0, 6'h00, 32'h0000_BEEF, 4'b0011, 0, 1, 1);
        applyStimulus(1, 6'h00, '0, 4'h0, 1, 0, 0);

        repeat (3) @(posedge clk);
        checkOutput("b_queue_drained", FW'(bq.size()), FW'(0));
        checkOutput("r_queue_drained", FW'(rq.size()), FW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed 4-register 32-bit cpu_reg slave.
- Adds configurable register count and width, byte strobes, and read-only (hardware-fed) registers.
- Adds per-register write pulses and SLVERR on out-of-range addresses.
- Sits between the AXI interconnect/VIP master and fabric logic needing CPU-visible control and status.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width in bits; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, address width; must satisfy 2^ADDR_WIDTH >= C_NUM_REGS*(DATA_WIDTH/8).
- C_NUM_REGS, 16, number of registers, 1..64.
- C_RO_MASK, 0, C_NUM_REGS-bit mask; bit set = register is read-only and reads from reg_in.
- C_RESET_VAL, 0, reset value applied to all read/write registers.

Ports:
- S_AXI_ACLK in 1: the single clock.
- S_AXI_ARESET in 1: asynchronous, active-high reset.
- S_AXI_AWADDR in ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in DATA_WIDTH; S_AXI_WSTRB in DATA_WIDTH/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out DATA_WIDTH; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- reg_out out C_NUM_REGS*DATA_WIDTH: flat register contents, reg k at [k*DW +: DW].
- reg_in in C_NUM_REGS*DATA_WIDTH: hardware values for read-only registers; slices of RW registers are unused.
- reg_wr_pulse out C_NUM_REGS: one-cycle pulse on the cycle register k is updated.

Behaviour:

Reset
- While S_AXI_ARESET=1, all outputs are 0 except RW registers, which hold C_RESET_VAL.
- All READY outputs are 0 during reset and rise on the first clock edge after deassert.
- Reset asserted mid-transaction aborts it silently; no B or R response is issued.

Address decode
- Word index = addr >> log2(DW/8); low byte-offset bits are ignored.
- Index >= C_NUM_REGS is out-of-range.

Write path: states WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP
- WR_IDLE: AWREADY=WREADY=1.
  - AW and W handshake in the same cycle N -> WR_RESP.
  - AW only -> WR_WAIT_W, address latched, AWREADY=0.
  - W only -> WR_WAIT_AW, data and strobe latched, WREADY=0.
- WR_WAIT_W / WR_WAIT_AW: the missing channel's READY=1; its handshake -> WR_RESP.
- Entering WR_RESP at edge N+1:
  - Register updated per byte lane where WSTRB=1.
  - reg_wr_pulse[k]=1 for that cycle only.
  - BVALID=1.
- WR_RESP: hold BVALID and BRESP stable until BREADY=1, then -> WR_IDLE.
- Only one outstanding write; AWREADY=WREADY=0 in WR_RESP.
- BRESP values:
  - OKAY (00) for in-range addresses.
  - SLVERR (10) for out-of-range addresses; no update, no pulse.
- WSTRB=0: OKAY, no update, no pulse.
- Write to a read-only register: OKAY, ignored, no pulse.

Read path: states RD_IDLE, RD_RESP
- RD_IDLE: ARREADY=1. AR handshake at edge N:
  - Data sampled at that edge; RDATA/RRESP valid with RVALID=1 from N+1.
  - RW register -> register value; RO register -> reg_in slice.
  - Out-of-range -> RDATA=0, RRESP=SLVERR.
- RD_RESP: ARREADY=0; hold RDATA/RRESP stable until RREADY=1, then -> RD_IDLE.

Concurrency
- Read and write paths are fully independent.
- Read handshake in the same cycle as a write update to the same register returns the old value.
- reg_out reflects updates at edge N+1 with no additional latency.

Decomposition:
- Package axi_lite_regfile_pkg holds:
  - RESP_OKAY, RESP_SLVERR constants.
  - wr_state_t and rd_state_t enums.
  - Function idx_in_range().
- One sub-module, axi_lite_regfile_wr_fsm: write-channel AW/W join and B response, producing a wr_en/wr_idx/wr_data/wr_strb strobe.
- The register array and read path stay in the top module.

Test Plan:
- Sequential writes: 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4, all OKAY; reg_wr_pulse bits 0..3 each high for exactly one cycle.
- Byte strobe: reg 0 = 0xAABBCCDD, write 0x11223344 with WSTRB=0b0101 -> read returns 0xAA22CC44.
- W before AW: WVALID at cycle 0, AWVALID at cycle 3 to 0x8 -> BVALID at cycle 4 and reg 2 updated.
- Backpressure: BREADY low 5 cycles -> BVALID and BRESP held, no second AW accepted.
- Out-of-range (C_NUM_REGS=4):
  - Write 0x10 -> BRESP=10, reg_out unchanged.
  - Read 0x10 -> RDATA=0, RRESP=10.
- Read-only: C_RO_MASK=0b0010, reg_in[1]=0xDEADBEEF; write 0x5 to 0x4 -> OKAY, no pulse, read 0x4 -> 0xDEADBEEF.
- Reset mid-operation: assert S_AXI_ARESET while BVALID=1 -> BVALID=0 immediately, all registers back to C_RESET_VAL.
